// File: rtl/muldiv_seq.sv
// Iterative MULT/DIV sequencer owning the HI/LO pair.
// One bit per cycle, then a sign-fixup cycle that writes HI/LO.
module muldiv_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 6,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [CTRL_WIDTH-1:0] ctrl,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out,
  output logic                  busy,
  output logic                  stall,
  output logic                  done
);
  localparam int W = DATA_WIDTH;

  localparam logic [CTRL_WIDTH-1:0] F_MFHI  = CTRL_WIDTH'('h10);
  localparam logic [CTRL_WIDTH-1:0] F_MTHI  = CTRL_WIDTH'('h11);
  localparam logic [CTRL_WIDTH-1:0] F_MFLO  = CTRL_WIDTH'('h12);
  localparam logic [CTRL_WIDTH-1:0] F_MTLO  = CTRL_WIDTH'('h13);
  localparam logic [CTRL_WIDTH-1:0] F_MULT  = CTRL_WIDTH'('h18);
  localparam logic [CTRL_WIDTH-1:0] F_MULTU = CTRL_WIDTH'('h19);
  localparam logic [CTRL_WIDTH-1:0] F_DIV   = CTRL_WIDTH'('h1A);
  localparam logic [CTRL_WIDTH-1:0] F_DIVU  = CTRL_WIDTH'('h1B);

  typedef enum logic [1:0] {
    S_IDLE, S_MUL, S_DIV, S_FIX
  } state_t;

  state_t r_state, w_next;

  logic [W-1:0]   r_hi, r_lo, r_a, r_b;
  logic [2*W-1:0] r_acc;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic r_sa, r_sb, r_div, r_dz, r_done;

  logic w_is_mul, w_is_div, w_is_md, w_is_hilo;
  logic w_busy, w_start, w_last, w_sgn, w_sa, w_sb;
  logic [W-1:0] w_abs_a, w_abs_b, w_q, w_r;
  logic [W:0]   w_add, w_rsh, w_sub;
  logic [2*W-1:0] w_mul_nxt, w_div_nxt;

  assign w_is_mul  = (ctrl == F_MULT) | (ctrl == F_MULTU);
  assign w_is_div  = (ctrl == F_DIV) | (ctrl == F_DIVU);
  assign w_is_md   = w_is_mul | w_is_div;
  assign w_is_hilo = w_is_md | (ctrl == F_MFHI) | (ctrl == F_MTHI)
                   | (ctrl == F_MFLO) | (ctrl == F_MTLO);

  assign w_busy  = (r_state != S_IDLE);
  assign w_start = valid & ~w_busy & w_is_md;
  assign w_last  = (r_cnt == CNT_WIDTH'(W - 1));

  assign w_sgn   = (ctrl == F_MULT) | (ctrl == F_DIV);
  assign w_sa    = w_sgn & rs_data[W-1];
  assign w_sb    = w_sgn & rt_data[W-1];
  assign w_abs_a = w_sa ? -rs_data : rs_data;
  assign w_abs_b = w_sb ? -rt_data : rt_data;

  // Shift-add: low half holds the unconsumed multiplier bits.
  assign w_add = {1'b0, r_acc[2*W-1:W]}
               + (r_acc[0] ? {1'b0, r_a} : {(W+1){1'b0}});
  assign w_mul_nxt = {w_add, r_acc[W-1:1]};

  // Restoring divide: upper half is remainder, lower half quotient.
  assign w_rsh = r_acc[2*W-1:W-1];
  assign w_sub = w_rsh - {1'b0, r_b};
  assign w_div_nxt = w_sub[W]
                   ? {w_rsh[W-1:0], r_acc[W-2:0], 1'b0}
                   : {w_sub[W-1:0], r_acc[W-2:0], 1'b1};

  assign w_q = r_acc[W-1:0];
  assign w_r = r_acc[2*W-1:W];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = w_is_div ? S_DIV : S_MUL;
      S_MUL:  if (w_last) w_next = S_FIX;
      S_DIV:  if (w_last) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_div  <= 1'b0;
      r_dz   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_a   <= w_abs_a;
            r_b   <= w_abs_b;
            r_sa  <= w_sa;
            r_sb  <= w_sb;
            r_div <= w_is_div;
            r_dz  <= (w_abs_b == '0);
            r_cnt <= '0;
            r_acc <= {{W{1'b0}}, w_is_div ? w_abs_a : w_abs_b};
          end
          if (valid & (ctrl == F_MTHI)) r_hi <= rs_data;
          if (valid & (ctrl == F_MTLO)) r_lo <= rs_data;
        end
        S_MUL: begin
          r_acc <= w_mul_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
        S_DIV: begin
          r_acc <= w_div_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          if (r_div) begin
            // Negating |rs| restores the original dividend on divide by zero.
            r_hi <= r_sa ? -w_r : w_r;
            r_lo <= r_dz ? '1 : ((r_sa ^ r_sb) ? -w_q : w_q);
          end else begin
            {r_hi, r_lo} <= (r_sa ^ r_sb) ? -r_acc : r_acc;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = w_busy;
  assign stall  = valid & w_busy & w_is_hilo;
  assign done   = r_done;
  assign hi_out = r_hi;
  assign lo_out = r_lo;

  always_comb begin
    result = '0;
    if (valid & ~stall & (ctrl == F_MFHI)) result = r_hi;
    if (valid & ~stall & (ctrl == F_MFLO)) result = r_lo;
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: results, latency, stall,
// HI/LO moves and mid-operation reset.
module tb_muldiv_seq;
  localparam logic [5:0] MFHI  = 6'h10;
  localparam logic [5:0] MTHI  = 6'h11;
  localparam logic [5:0] MFLO  = 6'h12;
  localparam logic [5:0] MTLO  = 6'h13;
  localparam logic [5:0] MULT  = 6'h18;
  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIV   = 6'h1A;
  localparam logic [5:0] DIVU  = 6'h1B;

  logic clk = 1'b0;
  logic rst, valid, busy, stall, done;
  logic [5:0] ctrl;
  logic [31:0] rs_data, rt_data, result, hi_out, lo_out;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  muldiv_seq #(
    .DATA_WIDTH(32),
    .CTRL_WIDTH(6),
    .CNT_WIDTH(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .valid(valid),
    .ctrl(ctrl),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .result(result),
    .hi_out(hi_out),
    .lo_out(lo_out),
    .busy(busy),
    .stall(stall),
    .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] c, input logic [31:0] a,
                       input logic [31:0] b);
    valid = 1'b1;
    ctrl = c;
    rs_data = a;
    rt_data = b;
    step();
    valid = 1'b0;
    ctrl = 6'h00;
    rs_data = 32'hDEADBEEF;
    rt_data = 32'h0BADF00D;
  endtask

  task automatic finish_op(input string tag, input logic [31:0] ehi,
                           input logic [31:0] elo, input int ecyc);
    int cyc = 0;
    int early = 0;
    while (busy && cyc < 100) begin
      cyc++;
      if (done) early++;
      step();
    end
    check({tag, ".cyc"}, cyc, ecyc);
    check({tag, ".early"}, early, 0);
    check({tag, ".done"}, {31'b0, done}, 1);
    check({tag, ".hi"}, hi_out, ehi);
    check({tag, ".lo"}, lo_out, elo);
    step();
    check({tag, ".done0"}, {31'b0, done}, 0);
  endtask

  initial begin
    int cyc;
    int d;
    rst = 1'b1;
    valid = 1'b0;
    ctrl = 6'h00;
    rs_data = '0;
    rt_data = '0;
    repeat (2) step();
    rst = 1'b0;
    #1;
    check("rst.hi", hi_out, 0);
    check("rst.lo", lo_out, 0);
    check("rst.busy", {31'b0, busy}, 0);
    check("rst.done", {31'b0, done}, 0);
    check("rst.stall", {31'b0, stall}, 0);

    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    finish_op("multu_max", 32'hFFFFFFFE, 32'h00000001, 33);
    issue(MULT, 32'hFFFFFFFD, 32'd7);
    finish_op("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFEB, 33);
    issue(MULT, 32'h80000000, 32'h80000000);
    finish_op("mult_min", 32'h40000000, 32'h00000000, 33);
    issue(DIVU, 32'd100, 32'd7);
    finish_op("divu", 32'd2, 32'd14, 33);
    issue(DIV, 32'hFFFFFFF9, 32'd2);
    finish_op("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    issue(DIV, 32'h80000000, 32'hFFFFFFFF);
    finish_op("div_ovf", 32'h00000000, 32'h80000000, 33);
    issue(DIVU, 32'd5, 32'd0);
    finish_op("divu_z", 32'd5, 32'hFFFFFFFF, 33);
    issue(DIV, 32'hFFFFFFFB, 32'd0);
    finish_op("div_z", 32'hFFFFFFFB, 32'hFFFFFFFF, 33);

    // mflo held from the cycle after acceptance
    issue(MULT, 32'd6, 32'd7);
    valid = 1'b1;
    ctrl = MFLO;
    #1;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      check("hold.stall", {31'b0, stall}, 1);
      check("hold.res", result, 0);
      step();
    end
    check("hold.cyc", cyc, 33);
    check("hold.done", {31'b0, done}, 1);
    check("hold.stall0", {31'b0, stall}, 0);
    check("hold.res42", result, 32'd42);
    valid = 1'b0;
    step();

    valid = 1'b1;
    ctrl = MTHI;
    rs_data = 32'h0000AAAA;
    step();
    valid = 1'b0;
    check("mthi.idle", hi_out, 32'h0000AAAA);

    issue(MULTU, 32'd2, 32'd3);
    valid = 1'b1;
    ctrl = 6'h20;
    #1;
    check("other.stall", {31'b0, stall}, 0);
    ctrl = MTHI;
    rs_data = 32'h00005555;
    #1;
    check("mthi.stall", {31'b0, stall}, 1);
    step();
    step();
    check("mthi.keep", hi_out, 32'h0000AAAA);
    valid = 1'b0;
    ctrl = 6'h00;
    finish_op("mthi_mul", 32'd0, 32'd6, 31);

    valid = 1'b1;
    ctrl = MTLO;
    rs_data = 32'h00001234;
    step();
    ctrl = MFLO;
    #1;
    check("mtlo.res", result, 32'h00001234);
    check("mtlo.stall", {31'b0, stall}, 0);
    ctrl = MFHI;
    #1;
    check("mfhi.res", result, 32'd0);
    valid = 1'b0;
    ctrl = 6'h00;
    step();

    issue(DIV, 32'd100, 32'd7);
    repeat (9) step();
    check("abort.busy1", {31'b0, busy}, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort.busy", {31'b0, busy}, 0);
    check("abort.hi", hi_out, 0);
    check("abort.lo", lo_out, 0);
    d = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) d++;
      step();
    end
    check("abort.nodone", d, 0);
    issue(MULTU, 32'd3, 32'd4);
    finish_op("post_rst", 32'd0, 32'd12, 33);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO register pair for the MIPS core.
- Decodes the R-type funct code (same encoding as the ALU ctrl field) and runs MULT/MULTU/DIV/DIVU over multiple cycles.
- Serves MFHI/MFLO/MTHI/MTLO, and raises a stall to the pipeline whenever a HI/LO-related instruction arrives while an operation is in flight.

Parameters:
- DATA_WIDTH, 32, operand/HI/LO width; must be even and >= 4.
- CTRL_WIDTH, 6, funct code width.
- CNT_WIDTH, 6, iteration counter width; must satisfy 2**CNT_WIDTH > DATA_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- valid  in  1  ctrl/operands are a real instruction this cycle
- ctrl  in  CTRL_WIDTH  funct: 0x10 mfhi, 0x11 mthi, 0x12 mflo, 0x13 mtlo, 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu
- rs_data  in  DATA_WIDTH  operand A (dividend / multiplicand / mthi-mtlo source)
- rt_data  in  DATA_WIDTH  operand B (divisor / multiplier)
- result  out  DATA_WIDTH  mfhi/mflo read data (combinational)
- hi_out  out  DATA_WIDTH  current HI register
- lo_out  out  DATA_WIDTH  current LO register
- busy  out  1  operation in flight
- stall  out  1  hold the issuing pipeline stage (combinational)
- done  out  1  one-cycle pulse when HI/LO receive a mult/div result

Behaviour:
- Reset: state IDLE, HI = LO = 0, busy = 0, done = 0, counter = 0, internal operand/accumulator registers = 0.
- Reset mid-operation aborts immediately: no done pulse, HI/LO cleared.
- States:
  - IDLE: waiting for an instruction.
  - MUL: shift-add multiply, one bit per cycle.
  - DIV: restoring divide, one bit per cycle.
  - FIX: sign fixup and HI/LO write.
- Accept (edge E0): valid & IDLE & ctrl in {0x18..0x1B}.
  - Capture |rs|, |rt|, and sign info (signed ops only); unsigned ops treat operands as magnitudes.
  - Go to MUL or DIV with counter = 0.
  - Operand changes after E0 are ignored.
- MUL/DIV: one iteration per edge (E1..E(DATA_WIDTH)), counter++. After counter reaches DATA_WIDTH-1, go to FIX.
- FIX at edge E(DATA_WIDTH+1):
  - Apply sign correction: product negated if operand signs differ; quotient negated if signs differ; remainder takes dividend sign.
  - Write HI/LO, return to IDLE.
- Timing:
  - busy = 1 in the cycles following E0 through edge E(DATA_WIDTH+1), i.e. DATA_WIDTH+1 cycles.
  - In the cycle after E(DATA_WIDTH+1): done = 1, busy = 0, and HI/LO hold the new values.
- Mult result: HI = upper half, LO = lower half of the 2*DATA_WIDTH product.
- Div result: LO = quotient, HI = remainder.
- Divide by zero (either signedness): LO = all ones, HI = original rs_data; fixup skipped; same latency.
- Signed overflow (INT_MIN / -1): LO = INT_MIN, HI = 0, the natural wrap result.
- mthi/mtlo when IDLE: HI/LO written from rs_data at the next edge; visible the following cycle; no busy.
- mfhi/mflo when IDLE: result = HI/LO combinationally in the same cycle.
- result = 0 whenever not (valid & !stall & ctrl in {0x10, 0x12}).
- stall = valid & busy & ctrl in {0x10..0x13, 0x18..0x1B}.
  - Stalled instructions are not accepted and must be re-presented by the pipeline.
  - stall never asserts while busy = 0.
- Instruction in the done cycle: valid in the done cycle is accepted normally (busy already 0); mfhi there returns the new result.
- Other ctrl codes with valid: ignored, never stall, no state change.
- Back-to-back: a new mult/div can be accepted in the done cycle.

Test Plan:
- multu rs=0xFFFFFFFF, rt=0xFFFFFFFF -> busy high exactly 33 cycles; done pulses once; HI=0xFFFFFFFE, LO=0x00000001.
- mult rs=0xFFFFFFFD (-3), rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; mult 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
- divu 100/7 -> LO=14, HI=2; div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu 5/0 and div -5/0 -> LO=0xFFFFFFFF, HI=5 and 0xFFFFFFFB respectively; done after the same 34-cycle latency.
- mflo held valid from the cycle after accepting mult 6x7 -> stall=1 every busy cycle, result=0 while stalled; in the done cycle stall=0 and result=42; mthi during busy also stalls with HI unchanged.
- mtlo 0x1234 then mflo next cycle -> result=0x1234, no stall.
- rst asserted 10 cycles into div -> next cycle busy=0, HI=LO=0, done never pulses; a following multu 3x4 gives LO=12.
